// File: rtl/pixel_port_arbiter_if.sv
// pixel_port_arbiter_if: shared LT24Display pixel bus between the drawing engines and the arbiter.
// Requester side: req, reqDone, reqXAddr, reqYAddr, reqPixelData, reqPixelWrite in; grant, reqPixelReady back.
// Display side:   xAddr, yAddr, pixelData, pixelWrite out to LT24Display; pixelReady back.
// Modports: slave = arbiter view, master = requesters + display view.
interface pixel_port_arbiter_if #(
   parameter int unsigned NUM_REQ = 4
);
   localparam int unsigned X_W = 8;
   localparam int unsigned Y_W = 9;
   localparam int unsigned D_W = 16;

   logic [NUM_REQ-1:0]     req;
   logic [NUM_REQ-1:0]     reqDone;
   logic [X_W*NUM_REQ-1:0] reqXAddr;
   logic [Y_W*NUM_REQ-1:0] reqYAddr;
   logic [D_W*NUM_REQ-1:0] reqPixelData;
   logic [NUM_REQ-1:0]     reqPixelWrite;
   logic [NUM_REQ-1:0]     reqPixelReady;
   logic [NUM_REQ-1:0]     grant;

   logic [X_W-1:0]         xAddr;
   logic [Y_W-1:0]         yAddr;
   logic [D_W-1:0]         pixelData;
   logic                   pixelWrite;
   logic                   pixelReady;

   modport slave (
      input  req, reqDone, reqXAddr, reqYAddr, reqPixelData, reqPixelWrite, pixelReady,
      output grant, reqPixelReady, xAddr, yAddr, pixelData, pixelWrite
   );

   modport master (
      output req, reqDone, reqXAddr, reqYAddr, reqPixelData, reqPixelWrite, pixelReady,
      input  grant, reqPixelReady, xAddr, yAddr, pixelData, pixelWrite
   );
endinterface

// File: rtl/pixel_port_arbiter.sv
// pixel_port_arbiter: grants the single LT24Display pixel port to one drawing engine at a time,
// holds the grant until that engine signals reqDone (or drops req), then inserts one dead cycle.
// Ports: clock, resetApp (async, active-high); bus (pixel_port_arbiter_if.slave) carrying the
// requester and display signals; busy, grantIdx, pixelCount status outputs.
// Build option: define PIXEL_ARB_RR_EN for round-robin selection; default is fixed priority
// (lowest index wins) with no pointer register.
module pixel_port_arbiter #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic                 clock,
   input  logic                 resetApp,
   pixel_port_arbiter_if.slave  bus,
   output logic                 busy,
   output logic [2:0]           grantIdx,
   output logic [16:0]          pixelCount
);

   localparam int unsigned IDX_W = 3;
   localparam int unsigned CNT_W = 17;
   localparam int unsigned X_W   = 8;
   localparam int unsigned Y_W   = 9;
   localparam int unsigned D_W   = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } arbStateT;

   arbStateT             state;
   arbStateT             stateNext;
   logic [NUM_REQ-1:0]   grantReg;
   logic [NUM_REQ-1:0]   winOneHot;
   logic [IDX_W-1:0]     winIdx;
   logic                 winFound;
   logic                 anyReq;
   logic                 releaseCond;
   logic                 accepted;
   logic                 loadGrant;
   logic                 dropGrant;
   logic                 countEn;

`ifdef PIXEL_ARB_RR_EN
   logic [IDX_W-1:0]     rrPtr;
`endif

   assign anyReq      = |bus.req;
   // Both terms are masked by the registered one-hot grant, so other requesters' reqDone is ignored.
   assign releaseCond = (|(bus.reqDone & grantReg)) | ~(|(bus.req & grantReg));
   assign accepted    = bus.pixelWrite & bus.pixelReady;
   assign bus.grant   = grantReg;

   // Winner selection: second pass is the wrap-around (or the whole search for fixed priority).
   always_comb begin
      winIdx   = '0;
      winFound = 1'b0;
`ifdef PIXEL_ARB_RR_EN
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (!winFound && bus.req[i] && (IDX_W'(i) >= rrPtr)) begin
            winFound = 1'b1;
            winIdx   = IDX_W'(i);
         end
      end
`endif
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (!winFound && bus.req[i]) begin
            winFound = 1'b1;
            winIdx   = IDX_W'(i);
         end
      end
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         winOneHot[i] = (winIdx == IDX_W'(i));
      end
   end

   // State register.
   always_ff @(posedge clock or posedge resetApp) begin
      if (resetApp) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state logic.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (anyReq)      stateNext = GRANT;
         GRANT:   if (releaseCond) stateNext = RELEASE;
         RELEASE: stateNext = anyReq ? GRANT : IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // FSM control outputs.
   always_comb begin
      loadGrant = 1'b0;
      dropGrant = 1'b0;
      countEn   = 1'b0;
      case (state)
         IDLE:    loadGrant = anyReq;
         GRANT: begin
            dropGrant = releaseCond;
            countEn   = accepted;
         end
         RELEASE: loadGrant = anyReq;
         default: ;
      endcase
   end

   // Grant, status and pixel counter registers.
   always_ff @(posedge clock or posedge resetApp) begin
      if (resetApp) begin
         grantReg   <= '0;
         busy       <= 1'b0;
         grantIdx   <= '0;
         pixelCount <= '0;
      end else if (loadGrant) begin
         grantReg   <= winOneHot;
         busy       <= 1'b1;
         grantIdx   <= winIdx;
         pixelCount <= '0;
      end else begin
         // The write presented in the releasing cycle still counts.
         if (countEn && (pixelCount != CNT_MAX)) begin
            pixelCount <= pixelCount + CNT_W'(1);
         end
         if (dropGrant) begin
            grantReg <= '0;
            busy     <= 1'b0;
         end
      end
   end

`ifdef PIXEL_ARB_RR_EN
   // Round-robin pointer advances past the releasing requester.
   always_ff @(posedge clock or posedge resetApp) begin
      if (resetApp) begin
         rrPtr <= '0;
      end else if (dropGrant) begin
         rrPtr <= (grantIdx == IDX_W'(NUM_REQ - 1)) ? '0 : grantIdx + IDX_W'(1);
      end
   end
`endif

   // Zero-latency data path: AND-OR mux steered by the registered one-hot grant.
   always_comb begin
      bus.xAddr      = '0;
      bus.yAddr      = '0;
      bus.pixelData  = '0;
      bus.pixelWrite = 1'b0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (grantReg[i]) begin
            bus.xAddr      = bus.reqXAddr[X_W*i +: X_W];
            bus.yAddr      = bus.reqYAddr[Y_W*i +: Y_W];
            bus.pixelData  = bus.reqPixelData[D_W*i +: D_W];
            bus.pixelWrite = bus.reqPixelWrite[i];
         end
      end
      bus.reqPixelReady = grantReg & {NUM_REQ{bus.pixelReady}};
   end

endmodule
